onehot_chunk_assembler: RTL and testbench

//  Receive end of the one-hot phased chunk transfer. A sender steps a one-hot

---
 rtl/onehot_chunk_assembler.sv | 69 ++++++
 tb/tb_onehot_chunk_assembler.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_chunk_assembler.sv
// onehot_chunk_assembler: gathers NUMBER one-hot-phased chunks into one word on a valid/ready output.
// Optional inPhase checking with a sticky error flag is enabled by defining PHASE_CHECK_EN.
module onehot_chunk_assembler #(
  parameter int NUMBER      = 4,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          inValid,
  output logic                          inReady,
  input  logic [CHUNK_WIDTH-1:0]        inData,
  input  logic [NUMBER-1:0]             inPhase,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [NUMBER*CHUNK_WIDTH-1:0] outData,
  output logic [NUMBER-1:0]             phase,
  output logic                          busy,
  output logic                          error
);
  localparam int W = CHUNK_WIDTH;
  localparam int PW = (NUMBER-1)*W;
  localparam logic [NUMBER-1:0] SLOT0 = NUMBER'(1);
  localparam logic [NUMBER-1:0] SLOT1 = NUMBER'(2);
  logic [PW-1:0] part, part_next;
  logic [NUMBER-1:0] phase_next;
  logic acc, mism, done;
  // the last slot is the only one that must wait for the output register
  assign inReady = !phase[NUMBER-1] | !outValid | outReady;
  assign acc = inValid & inReady;
  assign busy = !phase[0];
`ifdef PHASE_CHECK_EN
  assign mism = acc & (inPhase != phase);
  always_ff @(posedge clk) error <= reset & (error | mism);
`else
  assign mism = 1'b0;
  assign error = 1'b0;
`endif
  assign done = acc & phase[NUMBER-1] & !clear & !mism;
  always_comb begin
    part_next = part;
    phase_next = phase;
    if (clear) begin
      part_next = '0;
      phase_next = SLOT0;
    end else if (mism) begin
      part_next = '0;
      part_next[W-1:0] = inPhase[0] ? inData : '0;
      phase_next = inPhase[0] ? SLOT1 : SLOT0;
    end else if (acc) begin
      phase_next = {phase[NUMBER-2:0], phase[NUMBER-1]};
      for (int k = 0; k < NUMBER-1; k++)
        if (phase[k]) part_next[k*W +: W] = inData;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      phase <= SLOT0;
      part <= '0;
      outData <= '0;
      outValid <= 1'b0;
    end else begin
      phase <= phase_next;
      part <= part_next;
      outValid <= done | (outValid & !outReady);
      if (done) outData <= {inData, part};
    end
  end
endmodule

// File: tb/tb_onehot_chunk_assembler.sv
// tb_onehot_chunk_assembler: table vectors, directed corner sequences and random traffic
// checked against a slot-index reference model (NUMBER=4, CHUNK_WIDTH=8).
module tb_onehot_chunk_assembler;
  logic clk = 1'b0, reset, clear, inValid, inReady, outValid, outReady, busy, error;
  logic [7:0] inData;
  logic [3:0] inPhase, phase;
  logic [31:0] outData;
  int passed = 0, total = 0;

  onehot_chunk_assembler #(.NUMBER(4), .CHUNK_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .clear(clear), .inValid(inValid), .inReady(inReady),
    .inData(inData), .inPhase(inPhase), .outValid(outValid), .outReady(outReady),
    .outData(outData), .phase(phase), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // reference model: slot index, stored chunks, output register, sticky error
  int mp;
  logic [7:0] ms [4];
  logic mov, merr;
  logic [31:0] mod;

  function automatic logic m_ready(input logic ordy);
    return (mp != 3) || !mov || ordy;
  endfunction

  function automatic logic [3:0] m_phase();
    return 4'b0001 << mp;
  endfunction

  task automatic m_step(input logic rst_n, clr, v, input logic [7:0] d, input logic [3:0] iph, input logic ordy);
    logic acc, mism;
    if (!rst_n) begin
      mp = 0; mov = 0; merr = 0; mod = 0;
      for (int i = 0; i < 4; i++) ms[i] = 0;
      return;
    end
    acc = v && m_ready(ordy);
    mism = 0;
`ifdef PHASE_CHECK_EN
    mism = acc && (iph != m_phase());
`endif
    if (mov && ordy) mov = 0;
    if (mism) merr = 1;
    if (clr) mp = 0;
    else if (mism) begin
      if (iph[0]) begin ms[0] = d; mp = 1; end
      else mp = 0;
    end else if (acc) begin
      ms[mp] = d;
      if (mp == 3) begin
        mov = 1;
        mod = {d, ms[2], ms[1], ms[0]};
        mp = 0;
      end else mp++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_model();
    chk("phase", 32'(phase), 32'(m_phase()));
    chk("busy", 32'(busy), 32'(mp != 0));
    chk("outValid", 32'(outValid), 32'(mov));
    chk("outData", outData, mod);
    chk("error", 32'(error), 32'(merr));
  endtask

  logic rdy_s;
  // one clock: drive at negedge, sample inReady, step model at posedge, return at next negedge
  task automatic cyc(input logic rst_n, clr, v, input logic [7:0] d, input logic [3:0] iph, input logic ordy);
    reset = rst_n; clear = clr; inValid = v; inData = d; inPhase = iph; outReady = ordy;
    #1;
    rdy_s = inReady;
    if (rst_n) chk("inReady", 32'(rdy_s), 32'(m_ready(ordy)));
    @(posedge clk);
    m_step(rst_n, clr, v, d, iph, ordy);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic ordy);
    cyc(1, 0, 1, d, m_phase(), ordy);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic v; logic [7:0] d; logic ordy;
    logic rdy; logic [3:0] ph; logic ov; logic [31:0] od;
  } vec_t;
  vec_t vecs [15];

  initial begin
    vecs[0]  = '{1, 8'h11, 1, 1, 4'h2, 0, 32'h0};
    vecs[1]  = '{1, 8'h22, 1, 1, 4'h4, 0, 32'h0};
    vecs[2]  = '{1, 8'h33, 1, 1, 4'h8, 0, 32'h0};
    vecs[3]  = '{1, 8'h44, 1, 1, 4'h1, 1, 32'h44332211};
    vecs[4]  = '{0, 8'h00, 1, 1, 4'h1, 0, 32'h44332211};
    vecs[5]  = '{1, 8'hA0, 0, 1, 4'h2, 0, 32'h44332211};
    vecs[6]  = '{1, 8'hA1, 0, 1, 4'h4, 0, 32'h44332211};
    vecs[7]  = '{1, 8'hA2, 0, 1, 4'h8, 0, 32'h44332211};
    vecs[8]  = '{1, 8'hA3, 0, 1, 4'h1, 1, 32'hA3A2A1A0};
    vecs[9]  = '{1, 8'hB0, 0, 1, 4'h2, 1, 32'hA3A2A1A0};
    vecs[10] = '{1, 8'hB1, 0, 1, 4'h4, 1, 32'hA3A2A1A0};
    vecs[11] = '{1, 8'hB2, 0, 1, 4'h8, 1, 32'hA3A2A1A0};
    vecs[12] = '{1, 8'hB3, 0, 0, 4'h8, 1, 32'hA3A2A1A0};
    vecs[13] = '{1, 8'hB3, 1, 1, 4'h1, 1, 32'hB3B2B1B0};
    vecs[14] = '{0, 8'h00, 1, 1, 4'h1, 0, 32'hB3B2B1B0};

    reset = 0; clear = 0; inValid = 0; inData = 0; inPhase = 0; outReady = 0;
    @(negedge clk);
    do_reset();
    chk("rst_phase", 32'(phase), 32'h1);
    chk("rst_outValid", 32'(outValid), 32'h0);
    chk("rst_outData", outData, 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // back-to-back word, then pending word with last-slot stall and same-cycle drain
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, vecs[i].v, vecs[i].d, m_phase(), vecs[i].ordy);
      chk($sformatf("vec%0d_inReady", i), 32'(rdy_s), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
      chk($sformatf("vec%0d_outValid", i), 32'(outValid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d_outData", i), outData, vecs[i].od);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].ph != 4'h1));
    end

    // clear after two chunks, then a clean word
    send(8'h01, 1); send(8'h02, 1);
    cyc(1, 1, 0, 0, 0, 1);
    chk("clr_phase", 32'(phase), 32'h1);
    chk("clr_busy", 32'(busy), 32'h0);
    send(8'h55, 1); send(8'h56, 1); send(8'h57, 1); send(8'h58, 1);
    chk("clr_word", outData, 32'h58575655);
    chk("clr_valid", 32'(outValid), 32'h1);
    // clear with a same-cycle accept drops that chunk; pending output untouched
    send(8'h61, 0);
    cyc(1, 1, 1, 8'h99, m_phase(), 0);
    chk("clracc_phase", 32'(phase), 32'h1);
    chk("clracc_pending", 32'(outValid), 32'h1);
    chk("clracc_data", outData, 32'h58575655);
    cyc(1, 0, 0, 0, 0, 1);
    send(8'h71, 1); send(8'h72, 1); send(8'h73, 1); send(8'h74, 1);
    chk("clracc_word", outData, 32'h74737271);
    chk_model();

    // reset mid-word with a pending output
    send(8'h81, 0); send(8'h82, 0); send(8'h83, 0); send(8'h84, 0);
    send(8'h91, 0); send(8'h92, 0);
    chk("pre_rst_valid", 32'(outValid), 32'h1);
    do_reset();
    chk("mid_rst_phase", 32'(phase), 32'h1);
    chk("mid_rst_valid", 32'(outValid), 32'h0);
    chk("mid_rst_data", outData, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_error", 32'(error), 32'h0);
    send(8'hC0, 1);
    chk("post_rst_phase", 32'(phase), 32'h2);

    // phase mismatch then resync with inPhase[0]
    cyc(1, 0, 1, 8'hC1, 4'h4, 1);
`ifdef PHASE_CHECK_EN
    chk("mism_error", 32'(error), 32'h1);
    chk("mism_phase", 32'(phase), 32'h1);
`else
    chk("mism_error", 32'(error), 32'h0);
    chk("mism_phase", 32'(phase), 32'h4);
`endif
    chk_model();
    send(8'hD0, 1);
    cyc(1, 0, 1, 8'hD1, 4'h1, 1);
    chk_model();
    send(8'hD2, 1); send(8'hD3, 1); send(8'hD4, 1); send(8'hD5, 1);
    chk_model();

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] iph;
      int r;
      r = $urandom_range(0, 7);
      iph = (r < 6) ? m_phase() : (r == 6) ? 4'(4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7),
          8'($urandom), iph, ($urandom_range(0, 9) < 6));
      chk_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
